wvb_channel_arbiter: RTL and testbench

N-channel arbiter and multiplexer between per-channel waveform_buffer instances and a single downstream consumer (secondary_buffer or wvb_reader). It replaces the fixed 24-channel selection with a parametrised channel count. It adds selectable round-robin or fixed-priority arbitration, a per-channel enable mask, a grant channel index output, and a sticky stall watchdog. Once a channel is granted, the downstream sees a single waveform_buffer read interface, and the grant is held until that waveform's wvb_rddone.

---
 rtl/wvb_channel_arbiter.sv | 136 +++++++++++++
 tb/tb_wvb_channel_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wvb_channel_arbiter.sv
// N-channel arbiter/mux between per-channel waveform buffers and one downstream reader.
// Round-robin or fixed-priority grant, held until the waveform's rddone; sticky stall watchdog.
module wvb_channel_arbiter #(
  parameter int unsigned N_CHANNELS   = 24,
  parameter int unsigned P_CHAN_WIDTH = 5,
  parameter int unsigned P_DATA_WIDTH = 170,
  parameter int unsigned P_HDR_WIDTH  = 80,
  parameter int unsigned P_WDOG_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic                               mode,
  input  logic [N_CHANNELS-1:0]              chan_mask,
  input  logic [P_WDOG_WIDTH-1:0]            wdog_limit,
  input  logic                               wdog_clr,
  input  logic [N_CHANNELS-1:0]              wvb_hdr_empty,
  input  logic [N_CHANNELS*P_HDR_WIDTH-1:0]  wvb_hdr_data,
  input  logic [N_CHANNELS*P_DATA_WIDTH-1:0] wvb_data,
  output logic [N_CHANNELS-1:0]              wvb_hdr_rdreq,
  output logic [N_CHANNELS-1:0]              wvb_rdreq,
  output logic [N_CHANNELS-1:0]              wvb_rddone,
  output logic                               out_hdr_empty,
  output logic [P_HDR_WIDTH-1:0]             out_hdr_data,
  output logic [P_DATA_WIDTH-1:0]            out_data,
  output logic [P_CHAN_WIDTH-1:0]            out_chan,
  input  logic                               in_hdr_rdreq,
  input  logic                               in_rdreq,
  input  logic                               in_rddone,
  output logic                               wdog_err
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StLock = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [P_CHAN_WIDTH-1:0] sel_q, sel_d;
  logic [P_CHAN_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [P_CHAN_WIDTH-1:0] grant_idx;
  logic [N_CHANNELS-1:0]   req, req_hi, pick;
  logic [P_WDOG_WIDTH-1:0] wdog_cnt_q, wdog_cnt_d;
  logic                    wdog_err_q, wdog_err_d;
  logic                    wdog_set;
  logic                    locked, strobe, sel_empty;

  assign req    = ~wvb_hdr_empty & chan_mask;
  assign locked = (state_q == StLock);
  assign strobe = in_hdr_rdreq | in_rdreq | in_rddone;

  // Round-robin takes the lowest request at/above rr_ptr, else wraps to the lowest overall.
  always_comb begin
    req_hi = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      req_hi[i] = req[i] && (P_CHAN_WIDTH'(i) >= rr_ptr_q);
    end
    pick = (mode || (req_hi == '0)) ? req : req_hi;
    grant_idx = '0;
    for (int i = N_CHANNELS - 1; i >= 0; i--) begin
      if (pick[i]) grant_idx = P_CHAN_WIDTH'(i);
    end
  end

  // Data muxes follow registered sel; strobes only reach the granted channel while locked.
  always_comb begin
    out_hdr_data  = '0;
    out_data      = '0;
    sel_empty     = 1'b1;
    wvb_hdr_rdreq = '0;
    wvb_rdreq     = '0;
    wvb_rddone    = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      if (sel_q == P_CHAN_WIDTH'(i)) begin
        out_hdr_data     = wvb_hdr_data[i*P_HDR_WIDTH +: P_HDR_WIDTH];
        out_data         = wvb_data[i*P_DATA_WIDTH +: P_DATA_WIDTH];
        sel_empty        = wvb_hdr_empty[i];
        wvb_hdr_rdreq[i] = locked & in_hdr_rdreq;
        wvb_rdreq[i]     = locked & in_rdreq;
        wvb_rddone[i]    = locked & in_rddone;
      end
    end
  end

  assign out_hdr_empty = locked ? sel_empty : 1'b1;
  assign out_chan      = sel_q;
  assign wdog_err      = wdog_err_q;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      StIdle: begin
        if (en && (req != '0)) begin
          sel_d   = grant_idx;
          state_d = StLock;
        end
      end
      StLock: begin
        if (in_rddone) begin
          state_d = StIdle;
          if (!mode) begin
            rr_ptr_d = (sel_q == P_CHAN_WIDTH'(N_CHANNELS - 1)) ? '0 : sel_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Watchdog counts silent LOCK cycles; set beats clear when both land together.
  always_comb begin
    wdog_cnt_d = '0;
    if (locked && !strobe) begin
      wdog_cnt_d = (&wdog_cnt_q) ? wdog_cnt_q : wdog_cnt_q + 1'b1;
    end
    wdog_set   = locked && !strobe && (wdog_limit != '0) && (wdog_cnt_d == wdog_limit);
    wdog_err_d = wdog_set ? 1'b1 : (wdog_clr ? 1'b0 : wdog_err_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      rr_ptr_q   <= '0;
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end

endmodule

// File: tb/tb_wvb_channel_arbiter.sv
// Directed self-checking bench for wvb_channel_arbiter (24 channels, default widths).
module tb_wvb_channel_arbiter;

  localparam int N  = 24;
  localparam int CW = 5;
  localparam int DW = 170;
  localparam int HW = 80;
  localparam int WW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            en, mode, wdog_clr;
  logic [N-1:0]    chan_mask, wvb_hdr_empty;
  logic [WW-1:0]   wdog_limit;
  logic [N*HW-1:0] wvb_hdr_data;
  logic [N*DW-1:0] wvb_data;
  logic [N-1:0]    wvb_hdr_rdreq, wvb_rdreq, wvb_rddone;
  logic            out_hdr_empty;
  logic [HW-1:0]   out_hdr_data;
  logic [DW-1:0]   out_data;
  logic [CW-1:0]   out_chan;
  logic            in_hdr_rdreq, in_rdreq, in_rddone;
  logic            wdog_err;

  int checks = 0;
  int errors = 0;

  wvb_channel_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .mode          (mode),
    .chan_mask     (chan_mask),
    .wdog_limit    (wdog_limit),
    .wdog_clr      (wdog_clr),
    .wvb_hdr_empty (wvb_hdr_empty),
    .wvb_hdr_data  (wvb_hdr_data),
    .wvb_data      (wvb_data),
    .wvb_hdr_rdreq (wvb_hdr_rdreq),
    .wvb_rdreq     (wvb_rdreq),
    .wvb_rddone    (wvb_rddone),
    .out_hdr_empty (out_hdr_empty),
    .out_hdr_data  (out_hdr_data),
    .out_data      (out_data),
    .out_chan      (out_chan),
    .in_hdr_rdreq  (in_hdr_rdreq),
    .in_rdreq      (in_rdreq),
    .in_rddone     (in_rddone),
    .wdog_err      (wdog_err)
  );

  always #5 clk = ~clk;

  function automatic logic [HW-1:0] hdr_val(input int i);
    return {16'hC0DE, 56'h0, 8'(i)};
  endfunction

  function automatic logic [DW-1:0] data_val(input int i);
    return {8'(i), 154'h0, 8'(~i)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max_cycles && !ok; c++) begin
      if (out_hdr_empty === 1'b0) ok = 1'b1;
      else tick();
    end
    if (out_hdr_empty === 1'b0) ok = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; mode = 1'b0; chan_mask = '1; wvb_hdr_empty = ~24'h1;
    in_hdr_rdreq = 1'b1; in_rdreq = 1'b1; in_rddone = 1'b1; wdog_limit = '0; wdog_clr = 1'b0;
    repeat (2) tick();
    checks++; if (out_hdr_empty !== 1'b1) begin errors++;
      $display("FAIL reset_hdr_empty got %b want 1", out_hdr_empty); end
    checks++; if ({wvb_hdr_rdreq, wvb_rdreq, wvb_rddone} !== '0) begin errors++;
      $display("FAIL reset_strobes got %h/%h/%h want 0", wvb_hdr_rdreq, wvb_rdreq, wvb_rddone); end
    checks++; if (wdog_err !== 1'b0 || out_chan !== 5'd0) begin errors++;
      $display("FAIL reset_err_chan got err=%b chan=%0d want 0/0", wdog_err, out_chan); end
    in_hdr_rdreq = 1'b0; in_rdreq = 1'b0; in_rddone = 1'b0; wvb_hdr_empty = '1;
    rst = 1'b0;
    tick();
    checks++; if (out_hdr_empty !== 1'b1) begin errors++;
      $display("FAIL reset_idle_empty got %b want 1", out_hdr_empty); end
  endtask

  task automatic test_round_robin;
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    bit ok;
    mode = 1'b0; en = 1'b1; chan_mask = 24'h00000F; wvb_hdr_empty = ~24'h00000F;
    for (int g = 0; g < 5; g++) begin
      wait_grant(10, ok);
      checks++; if (!ok) begin errors++;
        $display("FAIL rr_grant_timeout g=%0d got empty=%b want 0", g, out_hdr_empty); end
      checks++; if (out_chan !== CW'(exp_seq[g])) begin errors++;
        $display("FAIL rr_chan g=%0d got %0d want %0d", g, out_chan, exp_seq[g]); end
      checks++; if (out_data !== data_val(exp_seq[g])) begin errors++;
        $display("FAIL rr_data g=%0d got %h want %h", g, out_data, data_val(exp_seq[g])); end
      in_hdr_rdreq = 1'b1; #1;
      checks++; if (wvb_hdr_rdreq !== (24'h1 << exp_seq[g])) begin errors++;
        $display("FAIL rr_hdr_rdreq g=%0d got %h want %h", g, wvb_hdr_rdreq, 24'h1 << exp_seq[g]); end
      tick(); in_hdr_rdreq = 1'b0; in_rdreq = 1'b1; #1;
      checks++; if (wvb_rdreq !== (24'h1 << exp_seq[g])) begin errors++;
        $display("FAIL rr_rdreq g=%0d got %h want %h", g, wvb_rdreq, 24'h1 << exp_seq[g]); end
      repeat (4) tick();
      in_rdreq = 1'b0;
      if (g == 4) wvb_hdr_empty = '1;
      in_rddone = 1'b1; #1;
      checks++; if (wvb_rddone !== (24'h1 << exp_seq[g])) begin errors++;
        $display("FAIL rr_rddone g=%0d got %h want %h", g, wvb_rddone, 24'h1 << exp_seq[g]); end
      tick(); in_rddone = 1'b0; #1;
      checks++; if (out_hdr_empty !== 1'b1) begin errors++;
        $display("FAIL rr_idle_gap g=%0d got empty=%b want 1", g, out_hdr_empty); end
      if (g < 4) begin
        tick();
        checks++; if (out_hdr_empty !== 1'b0) begin errors++;
          $display("FAIL rr_regrant g=%0d got empty=%b want 0", g, out_hdr_empty); end
      end
    end
  endtask

  task automatic test_fixed_priority;
    bit ok;
    mode = 1'b1; chan_mask = '1; wvb_hdr_empty = ~24'h00000A;
    for (int g = 0; g < 3; g++) begin
      wait_grant(10, ok);
      checks++; if (!ok || out_chan !== 5'd1) begin errors++;
        $display("FAIL fp_chan1 g=%0d got ok=%b chan=%0d want 1/1", g, ok, out_chan); end
      if (g == 2) wvb_hdr_empty[1] = 1'b1;
      in_rddone = 1'b1; tick(); in_rddone = 1'b0;
    end
    wait_grant(10, ok);
    checks++; if (!ok || out_chan !== 5'd3) begin errors++;
      $display("FAIL fp_chan3 got ok=%b chan=%0d want 1/3", ok, out_chan); end
    wvb_hdr_empty = '1;
    in_rddone = 1'b1; tick(); in_rddone = 1'b0;
    mode = 1'b0;
  endtask

  task automatic test_mask;
    int bad = 0;
    chan_mask = 24'h00000B; wvb_hdr_empty = ~24'h000004; in_rdreq = 1'b1;
    repeat (8) begin
      tick();
      if (out_hdr_empty !== 1'b1 || wvb_rdreq !== '0) bad++;
    end
    checks++; if (bad != 0) begin errors++;
      $display("FAIL mask_blocked got %0d bad cycles want 0", bad); end
    chan_mask[2] = 1'b1; #1;
    checks++; if (out_hdr_empty !== 1'b1) begin errors++;
      $display("FAIL mask_early got empty=%b want 1", out_hdr_empty); end
    tick();
    checks++; if (out_hdr_empty !== 1'b0 || out_chan !== 5'd2) begin errors++;
      $display("FAIL mask_grant got empty=%b chan=%0d want 0/2", out_hdr_empty, out_chan); end
    checks++; if (wvb_rdreq !== 24'h000004) begin errors++;
      $display("FAIL mask_rdreq got %h want 000004", wvb_rdreq); end
    in_rdreq = 1'b0;
    // Mask and enable drop during LOCK must not disturb the grant.
    chan_mask = '0; en = 1'b0;
    repeat (2) tick();
    checks++; if (out_hdr_empty !== 1'b0 || out_chan !== 5'd2) begin errors++;
      $display("FAIL mask_lock_hold got empty=%b chan=%0d want 0/2", out_hdr_empty, out_chan); end
    chan_mask = '1;
    in_rddone = 1'b1; tick(); in_rddone = 1'b0;
    repeat (3) tick();
    checks++; if (out_hdr_empty !== 1'b1) begin errors++;
      $display("FAIL en_low_no_grant got empty=%b want 1", out_hdr_empty); end
    wvb_hdr_empty = '1; en = 1'b1;
    tick();
  endtask

  task automatic test_chan23_wrap;
    logic [HW-1:0] a5 = {10{8'hA5}};
    bit ok;
    wvb_hdr_data[23*HW +: HW] = a5;
    wvb_hdr_empty = ~(24'h1 << 23);
    wait_grant(10, ok);
    checks++; if (!ok || out_chan !== 5'd23) begin errors++;
      $display("FAIL ch23_grant got ok=%b chan=%0d want 1/23", ok, out_chan); end
    checks++; if (out_hdr_data !== a5) begin errors++;
      $display("FAIL ch23_hdr got %h want %h", out_hdr_data, a5); end
    in_rdreq = 1'b1; #1;
    checks++; if (wvb_rdreq !== 24'h800000) begin errors++;
      $display("FAIL ch23_rdreq got %h want 800000", wvb_rdreq); end
    tick(); in_rdreq = 1'b0;
    wvb_hdr_empty = ~24'hC00001;
    in_rddone = 1'b1; tick(); in_rddone = 1'b0;
    tick();
    checks++; if (out_hdr_empty !== 1'b0 || out_chan !== 5'd0) begin errors++;
      $display("FAIL wrap_grant got empty=%b chan=%0d want 0/0", out_hdr_empty, out_chan); end
    in_rddone = 1'b1; tick(); in_rddone = 1'b0;
    tick();
    checks++; if (out_hdr_empty !== 1'b0 || out_chan !== 5'd22) begin errors++;
      $display("FAIL wrap_next got empty=%b chan=%0d want 0/22", out_hdr_empty, out_chan); end
    wvb_hdr_empty = '1;
    in_rddone = 1'b1; tick(); in_rddone = 1'b0;
    wvb_hdr_data[23*HW +: HW] = hdr_val(23);
  endtask

  task automatic test_watchdog;
    bit ok;
    wdog_limit = 16'd10; wvb_hdr_empty = ~(24'h1 << 5);
    wait_grant(10, ok);
    checks++; if (!ok || out_chan !== 5'd5) begin errors++;
      $display("FAIL wd_grant got ok=%b chan=%0d want 1/5", ok, out_chan); end
    in_rdreq = 1'b1; tick(); in_rdreq = 1'b0;
    repeat (9) tick();
    checks++; if (wdog_err !== 1'b0) begin errors++;
      $display("FAIL wd_early got %b want 0", wdog_err); end
    tick();
    checks++; if (wdog_err !== 1'b1) begin errors++;
      $display("FAIL wd_set got %b want 1", wdog_err); end
    checks++; if (out_hdr_empty !== 1'b0 || out_chan !== 5'd5) begin errors++;
      $display("FAIL wd_hold got empty=%b chan=%0d want 0/5", out_hdr_empty, out_chan); end
    wvb_hdr_empty = '1;
    in_rddone = 1'b1; tick(); in_rddone = 1'b0;
    tick();
    checks++; if (wdog_err !== 1'b1) begin errors++;
      $display("FAIL wd_sticky got %b want 1", wdog_err); end
    wdog_clr = 1'b1; tick(); wdog_clr = 1'b0;
    checks++; if (wdog_err !== 1'b0) begin errors++;
      $display("FAIL wd_clr got %b want 0", wdog_err); end
    wdog_limit = '0;
  endtask

  task automatic test_reset_mid_lock;
    bit ok;
    wvb_hdr_empty = ~(24'h1 << 7);
    wait_grant(10, ok);
    checks++; if (!ok || out_chan !== 5'd7) begin errors++;
      $display("FAIL rml_grant got ok=%b chan=%0d want 1/7", ok, out_chan); end
    in_rdreq = 1'b1; #1;
    checks++; if (wvb_rdreq !== 24'h000080) begin errors++;
      $display("FAIL rml_rdreq got %h want 000080", wvb_rdreq); end
    #2 rst = 1'b1; #1;
    checks++; if (wvb_rdreq !== '0 || out_hdr_empty !== 1'b1) begin errors++;
      $display("FAIL rml_async got rdreq=%h empty=%b want 0/1", wvb_rdreq, out_hdr_empty); end
    in_rdreq = 1'b0;
    tick(); rst = 1'b0; wvb_hdr_empty = ~24'h000081;
    tick();
    checks++; if (out_hdr_empty !== 1'b0 || out_chan !== 5'd0) begin errors++;
      $display("FAIL rml_resume got empty=%b chan=%0d want 0/0", out_hdr_empty, out_chan); end
    wvb_hdr_empty = '1;
    in_rddone = 1'b1; tick(); in_rddone = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      wvb_hdr_data[i*HW +: HW] = hdr_val(i);
      wvb_data[i*DW +: DW]     = data_val(i);
    end
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_mask();
    test_chan23_wrap();
    test_watchdog();
    test_reset_mid_lock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
